// File: rtl/word_to_byte_v_pkg.sv
// word_to_byte_v_pkg
//   Items shared by the byte-lane serializer and its bus interface:
//   - LANE_W  : default lane width (one byte)
//   - state_t : serializer state (IDLE holds no word, SEND presents lanes)
package word_to_byte_v_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_to_byte_v_if.sv
// word_to_byte_v_if
//   Bundles both handshakes of the serializer.
//   Word side : w_data/w_valid in, w_ready out (relative to the serializer)
//   Byte side : b_data/b_valid/b_last out, b_ready in
//   Status    : busy out (a word is held)
//   Modports  : slave  -> the serializer itself
//               master -> the environment (word producer + byte consumer)
//
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid && ready. A valid source holds data (and last) stable until the
// transfer; ready may change freely and never depends on valid.
interface word_to_byte_v_if
  import word_to_byte_v_pkg::*;
#(
  parameter int W = 32,
  parameter int B = LANE_W
) ();

  logic [W-1:0] w_data;
  logic         w_valid;
  logic         w_ready;
  logic [B-1:0] b_data;
  logic         b_valid;
  logic         b_ready;
  logic         b_last;
  logic         busy;

  modport slave (
    input  w_data, w_valid, b_ready,
    output w_ready, b_data, b_valid, b_last, busy
  );

  modport master (
    output w_data, w_valid, b_ready,
    input  w_ready, b_data, b_valid, b_last, busy
  );

endinterface

// File: rtl/word_to_byte_v.sv
// word_to_byte_v
//   Serializes one W-bit word into N = W/B lanes of B bits, lane 0 (LSB)
//   first. A new word may be accepted in the same cycle the final lane
//   leaves, so a continuous word stream yields one lane per cycle.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   bus       : word_to_byte_v_if.slave (word in, lanes out, busy)
//   dbg_state : current FSM state, for observation only
module word_to_byte_v
  import word_to_byte_v_pkg::*;
#(
  parameter int W = 32,
  parameter int B = LANE_W
) (
  input  logic            clk,
  input  logic            reset,
  word_to_byte_v_if.slave bus,
  output state_t          dbg_state
);

  localparam int N  = W / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  if ((W % B) != 0 || W < B) begin : g_bad_params
    $error("word_to_byte_v: W must be a multiple of B and at least B");
  end

  state_t          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   idx_q,   idx_d;
  logic            b_last_q, b_last_d;

  // Lane data and b_last come straight from flops; only w_ready looks at
  // b_ready combinationally so a new word can follow the final lane.
  assign bus.b_valid = (state_q == SEND);
  assign bus.b_data  = shreg_q[B-1:0];
  assign bus.b_last  = b_last_q;
  assign bus.busy    = (state_q == SEND);
  assign bus.w_ready = (state_q == IDLE) ||
                       ((state_q == SEND) && b_last_q && bus.b_ready);
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.w_valid) begin
          shreg_d = bus.w_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.b_ready) begin
          if (idx_q == LAST_IDX) begin
            // Word done: chain straight into the next word when one waits.
            if (bus.w_valid) begin
              shreg_d = bus.w_data;
              idx_d   = '0;
            end else begin
              idx_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_q >> B;
            idx_d   = idx_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Precompute the final-lane flag so b_last is registered, not decoded.
    b_last_d = (state_d == SEND) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      b_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      b_last_q <= b_last_d;
    end
  end

endmodule

// File: tb/tb_word_to_byte_v.sv
// tb_word_to_byte_v
//   Directed bench for word_to_byte_v in three widths (W=32, W=8, W=64,
//   all with B=8). Expected lanes are pushed when a word is driven and
//   popped by the monitor whenever a lane transfers.
module tb_word_to_byte_v;
  import word_to_byte_v_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_to_byte_v_if #(.W(32), .B(8)) bus32 ();
  word_to_byte_v_if #(.W(8),  .B(8)) bus8  ();
  word_to_byte_v_if #(.W(64), .B(8)) bus64 ();
  state_t st32, st8, st64;

  word_to_byte_v #(.W(32), .B(8)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave), .dbg_state(st32));
  word_to_byte_v #(.W(8),  .B(8)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave),  .dbg_state(st8));
  word_to_byte_v #(.W(64), .B(8)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave), .dbg_state(st64));

  // ---------------- scoreboard ----------------
  // Entry = {b_last, b_data}
  logic [8:0] exp_q32[$];
  logic [8:0] exp_q8[$];
  logic [8:0] exp_q64[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q32.push_back({(i == 3), w[i*8 +: 8]});
  endtask

  task automatic push64(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_q64.push_back({(i == 7), w[i*8 +: 8]});
  endtask

  task automatic mon_one(input string tag, input logic v, input logic r,
                         input logic l, input logic [7:0] d, inout logic [8:0] q[$]);
    if (v && r) begin
      n_checks++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s_unexpected: observed 0x%0h expected no lane", tag, d);
      end
      if (q.size() != 0) check(tag, {55'd0, l, d}, {55'd0, q.pop_front()});
    end
  endtask

  // ---------------- driver tasks ----------------
  // sample: look at outputs mid-cycle and retire any lane about to transfer
  task automatic sample();
    @(negedge clk);
    mon_one("lane32", bus32.b_valid, bus32.b_ready, bus32.b_last, bus32.b_data, exp_q32);
    mon_one("lane8",  bus8.b_valid,  bus8.b_ready,  bus8.b_last,  bus8.b_data,  exp_q8);
    mon_one("lane64", bus64.b_valid, bus64.b_ready, bus64.b_last, bus64.b_data, exp_q64);
  endtask

  // tick: advance past the next rising edge; inputs change only here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus32.w_valid = 1'b0; bus32.w_data = '0; bus32.b_ready = 1'b1;
    bus8.w_valid  = 1'b0; bus8.w_data  = '0; bus8.b_ready  = 1'b1;
    bus64.w_valid = 1'b0; bus64.w_data = '0; bus64.b_ready = 1'b1;
  endtask

  task automatic check_idle32(input string tag);
    check({tag, "_b_valid"}, 64'(bus32.b_valid), 64'd0);
    check({tag, "_busy"},    64'(bus32.busy),    64'd0);
    check({tag, "_w_ready"}, 64'(bus32.w_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();

    // Reset held over 3 edges with random inputs
    for (int i = 0; i < 3; i++) begin
      bus32.w_valid = 1'($urandom_range(0, 1)); bus32.w_data = $urandom;
      bus32.b_ready = 1'($urandom_range(0, 1));
      bus8.w_valid  = 1'($urandom_range(0, 1)); bus8.w_data  = 8'($urandom_range(0, 255));
      bus8.b_ready  = 1'($urandom_range(0, 1));
      bus64.w_valid = 1'($urandom_range(0, 1)); bus64.w_data = {$urandom, $urandom};
      bus64.b_ready = 1'($urandom_range(0, 1));
      tick();
      sample();
      check_idle32("rst");
      check("rst_b_data32", 64'(bus32.b_data), 64'h00);
      check("rst_b_last32", 64'(bus32.b_last), 64'd0);
      check("rst_state32",  64'(st32), 64'(IDLE));
      check("rst_busy8",    64'(bus8.busy),    64'd0);
      check("rst_w_ready64",64'(bus64.w_ready),64'd1);
    end
    tick();
    idle_inputs();
    reset = 1'b0;

    // Single word: 0x44332211 -> 11 22 33 44, lane 0 the cycle after accept
    bus32.w_data = 32'h44332211; bus32.w_valid = 1'b1; push32(32'h44332211);
    sample();
    check("t1_w_ready_idle", 64'(bus32.w_ready), 64'd1);
    check("t1_b_valid_idle", 64'(bus32.b_valid), 64'd0);
    tick();
    bus32.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t1_b_valid", 64'(bus32.b_valid), 64'd1);
      if (i == 1) check("t1_state", 64'(st32), 64'(SEND));
      tick();
    end
    check("t1_drained", 64'(exp_q32.size()), 64'd0);
    sample();
    check_idle32("t1_after");
    tick();

    // Back-to-back: 0xDDCCBBAA then 0x87654321, no gap
    bus32.w_data = 32'hDDCCBBAA; bus32.w_valid = 1'b1; push32(32'hDDCCBBAA);
    sample();
    check("t2_w_ready_idle", 64'(bus32.w_ready), 64'd1);
    tick();
    bus32.w_data = 32'h87654321; push32(32'h87654321);
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t2_w_ready_w0", 64'(bus32.w_ready), (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    bus32.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t2_b_valid_w1", 64'(bus32.b_valid), 64'd1);
      tick();
    end
    check("t2_drained", 64'(exp_q32.size()), 64'd0);
    sample();
    check_idle32("t2_after");
    tick();

    // Backpressure: lane 1 (0x0C) stalled 3 cycles, 7 cycles in total
    bus32.w_data = 32'h0A0B0C0D; bus32.w_valid = 1'b1; push32(32'h0A0B0C0D);
    sample();
    tick();
    bus32.w_valid = 1'b0;
    sample();                     // lane 0 transfers
    check("t3_w_ready_l0", 64'(bus32.w_ready), 64'd0);
    tick();
    bus32.b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t3_hold_data",  64'(bus32.b_data),  64'h0C);
      check("t3_hold_valid", 64'(bus32.b_valid), 64'd1);
      check("t3_hold_last",  64'(bus32.b_last),  64'd0);
      check("t3_w_ready",    64'(bus32.w_ready), 64'd0);
      tick();
    end
    bus32.b_ready = 1'b1;
    sample();                     // lane 1
    tick();
    sample();                     // lane 2
    check("t3_w_ready_l2", 64'(bus32.w_ready), 64'd0);
    tick();
    sample();                     // lane 3 (final)
    check("t3_w_ready_l3", 64'(bus32.w_ready), 64'd1);
    tick();
    check("t3_drained", 64'(exp_q32.size()), 64'd0);
    sample();
    check_idle32("t3_after");
    tick();

    // Reset mid-word: only 0x44 and 0x33 may leave; 0x22/0x11 are dropped
    bus32.w_data = 32'h11223344; bus32.w_valid = 1'b1;
    exp_q32.push_back({1'b0, 8'h44});
    exp_q32.push_back({1'b0, 8'h33});
    sample();
    tick();
    bus32.w_valid = 1'b0;
    sample();                     // lane 0 (0x44)
    tick();
    sample();                     // lane 1 (0x33) presented
    #1 reset = 1'b1;
    #1;
    check_idle32("t4_async");
    check("t4_b_data", 64'(bus32.b_data), 64'h00);
    check("t4_b_last", 64'(bus32.b_last), 64'd0);
    tick();
    reset = 1'b0;
    check("t4_drained", 64'(exp_q32.size()), 64'd0);
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t4_no_partial", 64'(bus32.b_valid), 64'd0);
      tick();
    end
    bus32.w_data = 32'h000000FF; bus32.w_valid = 1'b1; push32(32'h000000FF);
    sample();
    tick();
    bus32.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      tick();
    end
    check("t4_ff_drained", 64'(exp_q32.size()), 64'd0);

    // W=B=8: every byte is a whole word, w_ready stays 1
    bus8.w_data = 8'h5A; bus8.w_valid = 1'b1; exp_q8.push_back({1'b1, 8'h5A});
    sample();
    check("t5_w_ready_a", 64'(bus8.w_ready), 64'd1);
    tick();
    bus8.w_data = 8'hA5; exp_q8.push_back({1'b1, 8'hA5});
    sample();                     // 0x5A
    check("t5_w_ready_b", 64'(bus8.w_ready), 64'd1);
    check("t5_b_last",    64'(bus8.b_last),  64'd1);
    tick();
    bus8.w_valid = 1'b0;
    sample();                     // 0xA5
    check("t5_w_ready_c", 64'(bus8.w_ready), 64'd1);
    tick();
    sample();
    check("t5_idle_valid", 64'(bus8.b_valid), 64'd0);
    check("t5_drained", 64'(exp_q8.size()), 64'd0);
    tick();

    // W=64: bytes 01..08, b_last only on 0x08, then back to IDLE
    bus64.w_data = 64'h0807060504030201; bus64.w_valid = 1'b1; push64(64'h0807060504030201);
    sample();
    tick();
    bus64.w_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("t6_b_valid", 64'(bus64.b_valid), 64'd1);
      tick();
    end
    check("t6_drained", 64'(exp_q64.size()), 64'd0);
    sample();
    check("t6_state", 64'(st64), 64'(IDLE));
    check("t6_b_valid_after", 64'(bus64.b_valid), 64'd0);
    tick();

    // Second W=64 word proves the lane index restarted at 0
    bus64.w_data = 64'hF0E0D0C0B0A09080; bus64.w_valid = 1'b1; push64(64'hF0E0D0C0B0A09080);
    sample();
    tick();
    bus64.w_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      tick();
    end
    check("t6b_drained", 64'(exp_q64.size()), 64'd0);

    // ---------------- final report ----------------
    check("end_q32_empty", 64'(exp_q32.size()), 64'd0);
    check("end_q8_empty",  64'(exp_q8.size()),  64'd0);
    check("end_q64_empty", 64'(exp_q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
